// File: rtl/instr_fetch.sv
// Instruction fetch stage: tracks the PC, keeps at most one instruction-memory
// read outstanding, buffers returned words with their PCs, and hands them to decode.
module instr_fetch #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
  logic [INSTR_W-1:0] fifo_instr_q [DEPTH];
  logic [INSTR_W-1:0] fifo_instr_d [DEPTH];
  logic [ADDR_W-1:0]  fifo_pc_q [DEPTH];
  logic [ADDR_W-1:0]  fifo_pc_d [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic req_fire;
  logic push;
  logic pop;

  // A request is only offered when the buffer is guaranteed room for its response.
  assign imem_req_valid = (state_q == IDLE) && (count_q < FULL_CNT) &&
                          !redirect_valid && !reset;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign instr_valid = (count_q != '0);
  assign instr       = fifo_instr_q[rd_ptr_q];
  assign instr_pc    = fifo_pc_q[rd_ptr_q];

  assign push = (state_q == WAIT) && imem_rsp_valid && !redirect_valid;
  assign pop  = instr_valid && instr_ready && !redirect_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          state_d = IDLE;
        end else if (redirect_valid) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_rsp_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (req_fire) begin
      pc_d     = pc_q + ADDR_W'(1);
      req_pc_d = pc_q;
    end
  end

  // A redirect empties the buffer outright; stale entry contents are left in place
  // since they are unreachable until overwritten.
  always_comb begin
    fifo_instr_d = fifo_instr_q;
    fifo_pc_d    = fifo_pc_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    if (redirect_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        fifo_instr_d[wr_ptr_q] = imem_rsp_data;
        fifo_pc_d[wr_ptr_q]    = req_pc_q;
        wr_ptr_d               = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
      end
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      fifo_instr_q <= fifo_instr_d;
      fifo_pc_q    <= fifo_pc_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a queue-based model of the fetch rules checked every cycle,
// plus directed phases with hand-computed instruction streams.
module tb_instr_fetch;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [15:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [15:0] imem_rsp_data = 16'h0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [15:0] instr;
  logic [15:0] instr_pc;

  logic        reset_w = 1'b1;
  logic        w_req_valid;
  logic [15:0] w_req_addr;
  logic        w_rsp_valid = 1'b0;
  logic [15:0] w_rsp_data = 16'h0;
  logic        w_instr_valid;
  logic [15:0] w_instr;
  logic [15:0] w_instr_pc;

  int total = 0;
  int bad = 0;
  int cycle = 0;
  int mem_lat = 1;

  instr_fetch #(.ADDR_W(16), .INSTR_W(16), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc)
  );

  instr_fetch #(.ADDR_W(16), .INSTR_W(16), .DEPTH(DEPTH), .RESET_PC(16'hFFFE)) dut_wrap (
    .clk(clk), .reset(reset_w),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
    .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .redirect_valid(1'b0), .redirect_pc(16'h0000),
    .instr_valid(w_instr_valid), .instr_ready(1'b1),
    .instr(w_instr), .instr_pc(w_instr_pc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Memory for the main DUT: answers addr+0x100 mem_lat cycles after acceptance.
  logic        mem_acc = 1'b0;
  logic [15:0] mem_acc_addr = 16'h0;
  bit          mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [15:0] mem_addr = 16'h0;

  always @(negedge clk) begin
    if (!reset && imem_req_valid && imem_req_ready) begin
      mem_acc      = 1'b1;
      mem_acc_addr = imem_req_addr;
    end
  end

  always @(posedge clk) begin
    #1;
    imem_rsp_valid = 1'b0;
    if (reset) begin
      mem_pend = 1'b0;
      mem_acc  = 1'b0;
    end else begin
      if (mem_acc) begin
        mem_pend = 1'b1;
        mem_cnt  = mem_lat;
        mem_addr = mem_acc_addr;
        mem_acc  = 1'b0;
      end
      if (mem_pend) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_addr + 16'h0100;
          mem_pend       = 1'b0;
        end
      end
    end
  end

  // Memory for the wrap-around DUT: always ready, one-cycle latency.
  logic        w_acc = 1'b0;
  logic [15:0] w_acc_addr = 16'h0;
  always @(negedge clk) begin
    w_acc      = !reset_w && w_req_valid;
    w_acc_addr = w_req_addr;
  end
  always @(posedge clk) begin
    #1;
    w_rsp_valid = w_acc;
    w_rsp_data  = w_acc_addr + 16'h0100;
  end

  // Behavioural model: the buffer is a plain queue of {pc, instr} entries, and the
  // memory side is just "is a read outstanding, and is it still wanted".
  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ins;
  } entry_t;

  entry_t      m_q[$];
  logic [15:0] m_pc = 16'h0;
  logic [15:0] m_req_pc = 16'h0;
  bit          m_out = 1'b0;
  bit          m_discard = 1'b0;
  bit          m_exp_rv;
  entry_t      m_new;

  always @(negedge clk) begin
    m_exp_rv = !reset && !m_out && (m_q.size() < DEPTH) && !redirect_valid;
    checkOutput("req_valid", imem_req_valid, m_exp_rv);
    if (m_exp_rv) checkOutput("req_addr", imem_req_addr, m_pc);
    checkOutput("instr_valid", instr_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      checkOutput("instr", instr, m_q[0].ins);
      checkOutput("instr_pc", instr_pc, m_q[0].pc);
    end
    if (reset) begin
      m_q.delete();
      m_pc      = 16'h0000;
      m_out     = 1'b0;
      m_discard = 1'b0;
    end else if (redirect_valid) begin
      m_q.delete();
      m_pc = redirect_pc;
      if (m_out && imem_rsp_valid) begin
        m_out     = 1'b0;
        m_discard = 1'b0;
      end else if (m_out) begin
        m_discard = 1'b1;
      end
    end else begin
      if (m_q.size() != 0 && instr_ready) void'(m_q.pop_front());
      if (m_out && imem_rsp_valid) begin
        if (!m_discard) begin
          m_new.pc  = m_req_pc;
          m_new.ins = imem_rsp_data;
          m_q.push_back(m_new);
        end
        m_out     = 1'b0;
        m_discard = 1'b0;
      end
      if (m_exp_rv && imem_req_ready) begin
        m_out    = 1'b1;
        m_req_pc = m_pc;
        m_pc     = m_pc + 16'h0001;
      end
    end
  end

  // Consumer-side logs of what each DUT actually delivered.
  logic [15:0] log_pc[$];
  logic [15:0] log_ins[$];
  int          log_cyc[$];
  logic [15:0] w_log_pc[$];
  logic [15:0] w_log_ins[$];

  always @(negedge clk) begin
    if (!reset && instr_valid && instr_ready && !redirect_valid) begin
      log_pc.push_back(instr_pc);
      log_ins.push_back(instr);
      log_cyc.push_back(cycle);
    end
    if (!reset_w && w_instr_valid) begin
      w_log_pc.push_back(w_instr_pc);
      w_log_ins.push_back(w_instr);
    end
  end

  task automatic applyStimulus(input logic rr, input logic ir, input logic rv, input logic [15:0] rpc);
    @(posedge clk);
    #2;
    imem_req_ready = rr;
    instr_ready    = ir;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  task automatic startPhase(input string name, input int lat, input logic ir, input logic rr);
    $display("[TB] phase %s", name);
    @(posedge clk);
    #2;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    instr_ready    = ir;
    imem_req_ready = rr;
    mem_lat        = lat;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req_valid", imem_req_valid, 1'b0);
    checkOutput("rst_instr_valid", instr_valid, 1'b0);
    checkOutput("rst_instr", instr, 16'h0000);
    checkOutput("rst_instr_pc", instr_pc, 16'h0000);
    @(posedge clk);
    #2;
    reset = 1'b0;
    log_pc.delete();
    log_ins.delete();
    log_cyc.delete();
    @(negedge clk);
    checkOutput("first_req_valid", imem_req_valid, 1'b1);
    checkOutput("first_req_addr", imem_req_addr, 16'h0000);
  endtask

  task automatic waitPops(input int n, input int budget);
    int k = 0;
    while (log_pc.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    checkOutput("pops_arrived", log_pc.size() >= n, 1'b1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    reset_w = 1'b0;
  end

  initial begin
    bit found;
    int k;

    // Streaming with a 1-cycle memory: one instruction every 2 cycles.
    startPhase("stream", 1, 1'b1, 1'b1);
    waitPops(6, 60);
    for (int i = 0; i < 6 && i < log_pc.size(); i++) begin
      checkOutput("stream_pc", log_pc[i], 16'(i));
      checkOutput("stream_ins", log_ins[i], 16'(16'h0100 + i));
      if (i > 0) checkOutput("stream_gap", log_cyc[i] - log_cyc[i-1], 2);
    end

    // Consumer stalled: buffer fills to DEPTH and fetch stops.
    startPhase("stall", 1, 1'b0, 1'b1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("stall_req_valid", imem_req_valid, 1'b0);
    checkOutput("stall_instr_valid", instr_valid, 1'b1);
    checkOutput("stall_head_pc", instr_pc, 16'h0000);
    checkOutput("stall_head_ins", instr, 16'h0100);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    waitPops(5, 60);
    for (int i = 0; i < 5 && i < log_pc.size(); i++)
      checkOutput("stall_pc", log_pc[i], 16'(i));
    if (log_cyc.size() >= 4) checkOutput("stall_burst", log_cyc[3] - log_cyc[0], 3);

    // Redirect while the read of pc 5 is outstanding (3-cycle memory).
    startPhase("redirect_drop", 3, 1'b1, 1'b1);
    found = 1'b0;
    k = 0;
    while (!found && k < 200) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready && imem_req_addr == 16'h0005) found = 1'b1;
      k++;
    end
    checkOutput("drop_saw_req5", found, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0040);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    waitPops(7, 100);
    for (int i = 0; i < 5 && i < log_pc.size(); i++)
      checkOutput("drop_pc", log_pc[i], 16'(i));
    if (log_pc.size() >= 7) begin
      checkOutput("drop_after_pc", log_pc[5], 16'h0040);
      checkOutput("drop_after_ins", log_ins[5], 16'h0140);
      checkOutput("drop_after_pc2", log_pc[6], 16'h0041);
    end

    // Redirect coinciding with a response and a pop while two entries are buffered.
    startPhase("redirect_same", 1, 1'b0, 1'b1);
    found = 1'b0;
    k = 0;
    while (!found && k < 50) begin
      @(posedge clk);
      #2;
      if (imem_rsp_valid && m_q.size() == 2) begin
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0200;
        instr_ready    = 1'b1;
        found          = 1'b1;
      end
      k++;
    end
    checkOutput("same_trigger", found, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    @(negedge clk);
    checkOutput("same_empty", instr_valid, 1'b0);
    checkOutput("same_req_valid", imem_req_valid, 1'b1);
    checkOutput("same_req_addr", imem_req_addr, 16'h0200);
    waitPops(2, 40);
    if (log_pc.size() >= 2) begin
      checkOutput("same_pc0", log_pc[0], 16'h0200);
      checkOutput("same_ins0", log_ins[0], 16'h0300);
      checkOutput("same_pc1", log_pc[1], 16'h0201);
    end

    // Memory not ready: request held stable, PC does not advance.
    startPhase("backpressure", 1, 1'b1, 1'b0);
    repeat (4) begin
      @(negedge clk);
      checkOutput("bp_req_valid", imem_req_valid, 1'b1);
      checkOutput("bp_req_addr", imem_req_addr, 16'h0000);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    waitPops(2, 40);
    if (log_pc.size() >= 2) begin
      checkOutput("bp_pc0", log_pc[0], 16'h0000);
      checkOutput("bp_pc1", log_pc[1], 16'h0001);
    end

    // PC wrap-around on the second instance (RESET_PC = 0xFFFE).
    k = 0;
    while (w_log_pc.size() < 3 && k < 100) begin
      @(posedge clk);
      k++;
    end
    checkOutput("wrap_pops_arrived", w_log_pc.size() >= 3, 1'b1);
    if (w_log_pc.size() >= 3) begin
      checkOutput("wrap_pc0", w_log_pc[0], 16'hFFFE);
      checkOutput("wrap_pc1", w_log_pc[1], 16'hFFFF);
      checkOutput("wrap_pc2", w_log_pc[2], 16'h0000);
      checkOutput("wrap_ins0", w_log_ins[0], 16'h00FE);
      checkOutput("wrap_ins2", w_log_ins[2], 16'h0100);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage directly upstream of the CPU datapath. Maintains the program counter, issues word reads to instruction memory (at most one outstanding), buffers returned words with their PCs in a small prefetch FIFO, and presents them to the decode/register-file stage over a valid/ready handshake. A redirect input (branch/jump resolved downstream) flushes the buffer, squashes any in-flight read and restarts fetch at a new PC.

## Interface

- ADDR_W, 16, PC / instruction-memory word-address width
- INSTR_W, 16, instruction width
- DEPTH, 4, prefetch FIFO entries (power of 2, ≥2)
- RESET_PC, 0, PC loaded on reset
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  ADDR_W  word address of request
- imem_rsp_valid  in  1  read data valid (in order, ≥1 cycle after acceptance)
- imem_rsp_data  in  INSTR_W  read data
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  ADDR_W  restart PC
- instr_valid  out  1  FIFO head valid
- instr_ready  in  1  consumer takes head
- instr  out  INSTR_W  head instruction
- instr_pc  out  ADDR_W  PC of head instruction

## Operation

- Registers: pc, req_pc (address of in-flight read), FIFO (instr, pc pairs; rd/wr pointers; count 0..DEPTH), state.
- States: IDLE (no read outstanding), WAIT (read outstanding, keep), DROP (read outstanding, discard).
- imem_req_valid = (state==IDLE) && (count<DEPTH) && !redirect_valid; imem_req_addr = pc (combinational).
- IDLE: on req handshake → WAIT, req_pc<=pc, pc<=pc+1 (mod 2^ADDR_W, wraps silently).
- WAIT: rsp_valid && !redirect_valid → push {rsp_data, req_pc}, → IDLE. redirect_valid without rsp → DROP. redirect_valid with rsp same cycle → response discarded, → IDLE.
- DROP: rsp_valid → discard, → IDLE. Further redirect in DROP only updates pc.
- Any state, redirect_valid: pc<=redirect_pc, FIFO emptied (count 0, pointers 0), pop in same cycle ignored, no request issued that cycle.
- rsp_valid in IDLE is a protocol error: ignored.
- instr_valid = (count!=0); instr/instr_pc = head entry. Pop on instr_valid && instr_ready. Push and pop in same cycle: count unchanged. Push never occurs at count==DEPTH (guaranteed by issue rule).
- Consumer may hold instr_ready low indefinitely; head stays stable while instr_valid && !instr_ready.

## Timing

- Reset: pc=RESET_PC, state=IDLE, count=0, FIFO entries 0 → instr_valid=0, instr=0, instr_pc=0; imem_req_valid=0 during reset cycle (reset overrides). Reset mid-transaction abandons the in-flight read; its late response arrives in IDLE and is ignored.
- First request: cycle after reset deasserts, addr=RESET_PC.
- Response in cycle N → instr_valid high in N+1.
- Next request earliest cycle after response; peak throughput one instruction per 2 cycles with 1-cycle memory.
- Redirect in cycle N → FIFO empty at N+1; first request to redirect_pc in N+1 if IDLE, else in cycle after the dropped response.

## Test plan

- Reset then 1-cycle memory returning data=addr+0x100, instr_ready=1 → instr stream pc 0,1,2,… with instr 0x100,0x101,…, one per 2 cycles, no gaps or duplicates.
- instr_ready=0 for 20 cycles → exactly DEPTH=4 entries buffered, imem_req_valid low afterward; release → pcs 0..3 then 4 fetched in order.
- Redirect to 0x0040 while read of pc 5 outstanding (rsp 3 cycles later) → pc 5 data never appears; next instr_pc=0x0040.
- Redirect in same cycle as response and as instr_ready pop with 2 entries buffered → FIFO empty next cycle, response dropped, fetch resumes at redirect_pc.
- RESET_PC=0xFFFE → instr_pc sequence 0xFFFE, 0xFFFF, 0x0000.
- imem_req_ready held 0 for 5 cycles → imem_req_valid, imem_req_addr stable; pc unchanged until handshake.
